// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: accepts mul/div/mthi/mtlo/mfhi/mflo,
// runs a fixed-latency operation and commits the 64-bit result to HI/LO on completion.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_N   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_RAW = $clog2(MAX_N + 1);
    localparam int CNT_W   = (CNT_RAW < 4) ? 4 : ((CNT_RAW > 8) ? 8 : CNT_RAW);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [31:0]      hi_next, lo_next;
    logic [31:0]      pend_hi, pend_lo;
    logic [63:0]      result;

    function automatic logic [63:0] mul_s(input logic signed [31:0] x, input logic signed [31:0] y);
        logic signed [63:0] xe, ye, p;
        xe = {{32{x[31]}}, x};
        ye = {{32{y[31]}}, y};
        p  = xe * ye;
        return p;
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe, ye;
        xe = {32'd0, x};
        ye = {32'd0, y};
        return xe * ye;
    endfunction

    // Magnitude divide then re-sign: avoids the -2^31 / -1 overflow trap entirely.
    function automatic logic [63:0] div_s(input logic signed [31:0] x, input logic signed [31:0] y);
        logic [31:0] ux, uy, q, r, quot, rem;
        ux   = x[31] ? -x : x;
        uy   = y[31] ? -y : y;
        q    = ux / uy;
        r    = ux % uy;
        quot = (x[31] ^ y[31]) ? -q : q;
        rem  = x[31] ? -r : r;
        return {rem, quot};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] x, input logic [31:0] y);
        return {x % y, x / y};
    endfunction

    assign busy  = (state == RUN);
    assign start = (op >= OP_MULT) && (op <= OP_DIVU) && !flush && !busy;

    // Divide by zero keeps the current HI/LO as the pending result.
    always_comb begin
        result = {hi, lo};
        case (op)
            OP_MULT:  result = mul_s(a, b);
            OP_MULTU: result = mul_u(a, b);
            OP_DIV:   if (b != 32'd0) result = div_s(a, b);
            OP_DIVU:  if (b != 32'd0) result = div_u(a, b);
            default:  result = {hi, lo};
        endcase
    end

    always_comb begin
        state_next = state;
        count_next = count;
        hi_next    = hi;
        lo_next    = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
                end else if (!flush && op == OP_MTHI) begin
                    hi_next = a;
                end else if (!flush && op == OP_MTLO) begin
                    lo_next = a;
                end
            end
            RUN: begin
                count_next = count - CNT_ONE;
                if (count == CNT_ONE) begin
                    hi_next    = pend_hi;
                    lo_next    = pend_lo;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            hi    <= hi_next;
            lo    <= lo_next;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            pend_hi <= result[63:32];
            pend_lo <= result[31:0];
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (op == OP_MFHI) rd_data = hi;
        else if (op == OP_MFLO) rd_data = lo;
    end

    illegal_op_while_busy: assert property (@(posedge clk) disable iff (reset)
        busy |-> !((op >= OP_MULT) && (op <= OP_MTLO)));

endmodule
